cic_cfg_ctl: RTL
================

# cic_cfg_ctl

Configuration controller that sits directly upstream of the 4-stage CIC interpolator/decimator and drives its `cin`/`cwr` configuration port on `cclk`. It accepts a decimation/interpolation factor N and a direction from the host. It computes the gain word that normalises CIC filter gain: N^4 for receive, N^3 for transmit. It then writes the gain word and the N word to the CIC in two consecutive cycles. A manual mode passes a host-supplied gain straight through.

## Interface
- RX_TARGET, 46: receive full-scale exponent; target total gain 2^46.
- TX_TARGET, 42: transmit full-scale exponent.
- N_MIN, 8: smallest legal N.
- cclk  in  1  configuration clock.
- rst  in  1  reset rst, synchronous, active-high; clock cclk.
- req_valid  in  1  request present.
- req_ready  out  1  high in IDLE only; transfer when valid & ready.
- req_xmt  in  1  0=receive (k=4, RX_TARGET, ge 0..31, gm ≤1023); 1=transmit (k=3, TX_TARGET, ge 8..31, gm ≤256).
- req_man  in  1  1=use req_ge/req_gm unmodified.
- req_n  in  12  factor N.
- req_ge  in  5  manual exponent.
- req_gm  in  10  manual mantissa (4.6 fixed point).
- cin  out  16  config word; 0 when cwr=0.
- cwr  out  2  one-hot write strobe: 01=gain {0,ge[4:0],gm[9:0]}, 10=N {4'h0,N}.
- done  out  1  one-cycle pulse after the N write, or on rejection.
- sat  out  1  sticky per request: gain clamped.
- err  out  1  sticky per request: request rejected.
- stat_ge  out  5  last exponent written.
- stat_gm  out  10  last mantissa written.

## Operation
- States are IDLE, SQ, PW, LZD, DIV, ADJ, WR_G, WR_N, DONE.
- IDLE:
  - On transfer, latch all request fields and clear sat/err.
  - If N < N_MIN, set err and go to DONE; no cwr strobes are issued.
  - If req_man=1, go to WR_G.
  - Otherwise go to SQ.
- SQ: s = N*N, 24 bits, unsigned.
- PW: P = s*s for rx, or s*N for tx. P is 48 bits and cannot overflow (4095^4 < 2^48).
- LZD:
  - p = index of the leading one of P.
  - d = P >> (p-9), 10 bits, range 512..1023.
  - p ≥ 9 always holds because N ≥ 8.
- DIV: q = floor(65536/d), range 64..128. Computed by restoring division, one quotient bit per cycle MSB first, 8 cycles.
- ADJ:
  - e = T - p - 1, signed, where T is the selected target.
  - If e > 31: ge = 31 and gm = q << (e-31).
  - If gm exceeds the mode cap, gm = cap and sat is set.
  - If e < ge_min: ge = ge_min, gm = q, sat is set.
  - Otherwise ge = e, gm = q.
- WR_G: cwr=01, cin = gain word; update stat_ge/stat_gm.
- WR_N: cwr=10, cin = {4'h0,N}.
- DONE: pulse done, then return to IDLE.
- Requests presented while busy are not accepted, because req_ready=0 outside IDLE.
- Reset mid-operation:
  - The next cycle shows IDLE, cwr=0, cin=0, done=0, sat=0, err=0.
  - No strobe is issued after rst.
  - If rst falls between WR_G and WR_N, the N write is abandoned.

## Timing
- Reset values: req_ready=1 (the cycle after rst deasserts), cin=0, cwr=0, done=0, sat=0, err=0, stat_ge=0, stat_gm=0.
- Auto mode, counting the transfer as cycle 0:
  - SQ 1, PW 2, LZD 3, DIV 4–11, ADJ 12.
  - WR_G 13, WR_N 14, done 15, req_ready high at 16.
- Manual mode: WR_G 1, WR_N 2, done 3.
- Rejection: err high from cycle 1; done at 1.
- Outputs are registered.
- Strobes last exactly one cycle and are never simultaneous.

## Structure
- Package cic_cfg_pkg holds:
  - the state enum;
  - RX_K=4 and TX_K=3;
  - gain caps (1023, 256);
  - ge minimums (0, 8);
  - the field-position constants of the gain word.
- One sub-module, cic_cfg_recip: an 8-cycle restoring divider computing 65536/d.
  - Ports: start, d[9:0], q[7:0], busy.
  - Reset is shared with the parent.

## Test plan
- Rx, N=8:
  - Expected intermediates: P=4096, p=12, d=512, q=128, e=33.
  - Cycle 13: cin=0x7E00 with cwr=01 (ge=31, gm=512).
  - Cycle 14: cin=0x0008 with cwr=10.
  - sat=0.
- Rx, N=1000:
  - Expected intermediates: p=39, d=931, q=70, ge=6.
  - Gain write cin=0x1846, then N write cin=0x03E8.
  - done at cycle 15.
- Tx, N=4095:
  - Expected intermediates: p=35, d=1023, q=64, e=6.
  - Clamped result: gain write cin=0x2040 (ge=8), N write cin=0x0FFF.
  - sat=1.
- Rx, N=5:
  - err=1 and done at cycle 1.
  - cwr stays 00.
  - req_ready returns at cycle 2.
- Manual, ge=3, gm=100, N=64:
  - Cycle 1: cin=0x0C64 with cwr=01.
  - Cycle 2: cin=0x0040 with cwr=10.
  - done at cycle 3.
  - A second req_valid at cycle 1 is not accepted.
- rst asserted at cycle 7 of an auto request:
  - No cwr strobes occur.
  - All outputs return to their reset values.
  - A following N=8 request reproduces test 1 exactly.

Source files
------------

// File: rtl/cic_cfg_pkg.sv
// Shared definitions for the CIC configuration controller: state codes,
// per-direction filter constants and the layout of the gain configuration word.
package cic_cfg_pkg;

   typedef logic [3:0] state_t;

   localparam state_t ST_IDLE = 4'd0;
   localparam state_t ST_SQ   = 4'd1;
   localparam state_t ST_PW   = 4'd2;
   localparam state_t ST_LZD  = 4'd3;
   localparam state_t ST_DIV  = 4'd4;
   localparam state_t ST_ADJ  = 4'd5;
   localparam state_t ST_WR_G = 4'd6;
   localparam state_t ST_WR_N = 4'd7;
   localparam state_t ST_DONE = 4'd8;

   localparam int RX_K = 4;
   localparam int TX_K = 3;

   localparam logic [9:0] RX_GM_CAP = 10'd1023;
   localparam logic [9:0] TX_GM_CAP = 10'd256;
   localparam logic [4:0] RX_GE_MIN = 5'd0;
   localparam logic [4:0] TX_GE_MIN = 5'd8;

   localparam int GW_GM_LSB = 0;
   localparam int GW_GM_MSB = 9;
   localparam int GW_GE_LSB = 10;
   localparam int GW_GE_MSB = 14;
   localparam int GW_RSV    = 15;

   localparam logic [1:0] CWR_GAIN = 2'b01;
   localparam logic [1:0] CWR_N    = 2'b10;

   // Gain word as the CIC expects it: reserved top bit, exponent, 4.6 mantissa.
   function automatic logic [15:0] gain_word(input logic [4:0] ge, input logic [9:0] gm);
      gain_word = '0;
      gain_word[GW_RSV] = 1'b0;
      gain_word[GW_GE_MSB:GW_GE_LSB] = ge;
      gain_word[GW_GM_MSB:GW_GM_LSB] = gm;
   endfunction

endpackage

// File: rtl/cic_cfg_recip.sv
// Restoring divider producing floor(65536/d) for a normalised 10-bit d,
// one quotient bit per cycle, most significant bit first.
module cic_cfg_recip
   import cic_cfg_pkg::*;
(
   input  logic       cclk,
   input  logic       rst,
   input  logic       start,
   input  logic [9:0] d,
   output logic [7:0] q,
   output logic       busy
);

   logic [16:0] rem;
   logic [16:0] dsh;
   logic [3:0]  cnt;

   // d is at least 512, so the quotient never needs more than 8 bits and the
   // divisor starts aligned to quotient bit 7.
   always_ff @(posedge cclk) begin
      if (rst) begin
         rem <= '0;
         dsh <= '0;
         cnt <= '0;
         q   <= '0;
      end else if (start) begin
         rem <= 17'h10000;
         dsh <= {d, 7'd0};
         cnt <= 4'd8;
         q   <= '0;
      end else if (cnt != 4'd0) begin
         if (rem >= dsh) begin
            rem <= rem - dsh;
            q   <= {q[6:0], 1'b1};
         end else begin
            q   <= {q[6:0], 1'b0};
         end
         dsh <= dsh >> 1;
         cnt <= cnt - 4'd1;
      end
   end

   assign busy = (cnt != 4'd0);

endmodule

// File: rtl/cic_cfg_ctl.sv
// Computes the CIC gain-normalisation word from N and direction, then writes
// the gain and N words to the CIC configuration port on consecutive cycles.
module cic_cfg_ctl
   import cic_cfg_pkg::*;
#(
   parameter int RX_TARGET = 46,
   parameter int TX_TARGET = 42,
   parameter int N_MIN     = 8
)(
   input  logic        cclk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_xmt,
   input  logic        req_man,
   input  logic [11:0] req_n,
   input  logic [4:0]  req_ge,
   input  logic [9:0]  req_gm,
   output logic [15:0] cin,
   output logic [1:0]  cwr,
   output logic        done,
   output logic        sat,
   output logic        err,
   output logic [4:0]  stat_ge,
   output logic [9:0]  stat_gm
);

   state_t      state;
   logic [11:0] n_r;
   logic        xmt_r;
   logic [23:0] s_r;
   logic [47:0] prod_r;
   logic [5:0]  p_r;
   logic [2:0]  div_cnt;

   logic [47:0] pw_mult;
   logic [5:0]  lzd_lead;
   logic [9:0]  lzd_d;
   logic        rcp_start;
   logic [7:0]  rcp_q;
   logic        rcp_busy;

   int          adj_e;
   logic [15:0] adj_gm_wide;
   logic [9:0]  adj_cap;
   logic [4:0]  adj_ge_min;
   logic [4:0]  adj_ge;
   logic [9:0]  adj_gm;
   logic        adj_sat;

   // Receive raises s=N^2 to N^4, transmit only to N^3.
   always_comb begin
      pw_mult = {36'd0, n_r};
      if ((xmt_r ? TX_K : RX_K) == RX_K) begin
         pw_mult = {24'd0, s_r};
      end
   end

   // Leading-one position and the 10-bit normalised mantissa below it.
   always_comb begin
      lzd_lead = '0;
      for (int i = 0; i < 48; i++) begin
         if (prod_r[i]) lzd_lead = 6'(i);
      end
      lzd_d = 10'(prod_r >> (lzd_lead - 6'd9));
   end

   assign rcp_start = (state == ST_LZD);

   cic_cfg_recip u_recip (
      .cclk  (cclk),
      .rst   (rst),
      .start (rcp_start),
      .d     (lzd_d),
      .q     (rcp_q),
      .busy  (rcp_busy)
   );

   // Exponent lands outside the CIC's range at both ends; overshoot is folded
   // into the mantissa, undershoot is pinned to the minimum and flagged.
   always_comb begin
      adj_cap     = xmt_r ? TX_GM_CAP : RX_GM_CAP;
      adj_ge_min  = xmt_r ? TX_GE_MIN : RX_GE_MIN;
      adj_e       = (xmt_r ? TX_TARGET : RX_TARGET) - int'(p_r) - 1;
      adj_gm_wide = {8'd0, rcp_q};
      adj_ge      = '0;
      adj_gm      = '0;
      adj_sat     = 1'b0;
      if (adj_e > 31) begin
         adj_ge      = 5'd31;
         adj_gm_wide = adj_gm_wide << (adj_e - 31);
         if (adj_gm_wide > {6'd0, adj_cap}) begin
            adj_gm  = adj_cap;
            adj_sat = 1'b1;
         end else begin
            adj_gm  = adj_gm_wide[9:0];
         end
      end else if (adj_e < int'(adj_ge_min)) begin
         adj_ge  = adj_ge_min;
         adj_gm  = {2'd0, rcp_q};
         adj_sat = 1'b1;
      end else begin
         adj_ge  = 5'(adj_e);
         adj_gm  = {2'd0, rcp_q};
      end
   end

   assign req_ready = (state == ST_IDLE);

   // Sequencer; every output is registered on entry to the state that shows it.
   always_ff @(posedge cclk) begin
      if (rst) begin
         state   <= ST_IDLE;
         n_r     <= '0;
         xmt_r   <= 1'b0;
         s_r     <= '0;
         prod_r  <= '0;
         p_r     <= '0;
         div_cnt <= '0;
         cin     <= '0;
         cwr     <= '0;
         done    <= 1'b0;
         sat     <= 1'b0;
         err     <= 1'b0;
         stat_ge <= '0;
         stat_gm <= '0;
      end else begin
         cin  <= '0;
         cwr  <= '0;
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  n_r   <= req_n;
                  xmt_r <= req_xmt;
                  sat   <= 1'b0;
                  err   <= 1'b0;
                  if (int'(req_n) < N_MIN) begin
                     err   <= 1'b1;
                     done  <= 1'b1;
                     state <= ST_DONE;
                  end else if (req_man) begin
                     cwr     <= CWR_GAIN;
                     cin     <= gain_word(req_ge, req_gm);
                     stat_ge <= req_ge;
                     stat_gm <= req_gm;
                     state   <= ST_WR_G;
                  end else begin
                     state <= ST_SQ;
                  end
               end
            end
            ST_SQ: begin
               s_r   <= {12'd0, n_r} * {12'd0, n_r};
               state <= ST_PW;
            end
            ST_PW: begin
               prod_r <= {24'd0, s_r} * pw_mult;
               state  <= ST_LZD;
            end
            ST_LZD: begin
               p_r     <= lzd_lead;
               div_cnt <= '0;
               state   <= ST_DIV;
            end
            ST_DIV: begin
               div_cnt <= div_cnt + 3'd1;
               if (div_cnt == 3'd7) state <= ST_ADJ;
            end
            ST_ADJ: begin
               if (!rcp_busy) begin
                  cwr     <= CWR_GAIN;
                  cin     <= gain_word(adj_ge, adj_gm);
                  stat_ge <= adj_ge;
                  stat_gm <= adj_gm;
                  sat     <= adj_sat;
                  state   <= ST_WR_G;
               end
            end
            ST_WR_G: begin
               cwr   <= CWR_N;
               cin   <= {4'h0, n_r};
               state <= ST_WR_N;
            end
            ST_WR_N: begin
               done  <= 1'b1;
               state <= ST_DONE;
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
